mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the multicycle MIPS-subset datapath. Takes operands from the A and B register outputs on a start pulse from the control unit. Iterates one bit per cycle. Writes a 64-bit result into internal HI/LO registers that feed the MFHI/MFLO write-back path. Reports busy/done so the control unit can stall in a wait state.

---
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: one shift-add or restoring-divide
// step per cycle on operand magnitudes, sign-corrected into HI/LO on completion.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_op;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_mag_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_div_zero;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [2*WIDTH-1:0]   w_shift;
   logic [WIDTH:0]       w_diff;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_step;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_res_hi;
   logic [WIDTH-1:0]     w_res_lo;

   // Magnitudes are unsigned: the most negative value maps onto 2^(WIDTH-1).
   assign w_mag_a = a_in[WIDTH-1] ? (~a_in + ONE_W) : a_in;
   assign w_mag_b = b_in[WIDTH-1] ? (~b_in + ONE_W) : b_in;

   always_comb begin
      w_mul_sum  = '0;
      w_mul_next = '0;
      w_shift    = '0;
      w_diff     = '0;
      w_div_next = '0;
      w_step     = '0;
      w_prod     = '0;
      w_res_hi   = '0;
      w_res_lo   = '0;

      // Multiply: multiplier sits in the low half and shifts out LSB first.
      w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
      w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

      // Divide: upper half is the partial remainder, quotient bits enter at LSB.
      w_shift    = {r_acc[2*WIDTH-2:0], 1'b0};
      w_diff     = {1'b0, w_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_mag_b};
      w_div_next = w_diff[WIDTH] ? w_shift : {w_diff[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};

      w_step = r_op ? w_div_next : w_mul_next;

      if (r_op) begin
         w_res_lo = r_neg_q ? (~w_step[WIDTH-1:0] + ONE_W) : w_step[WIDTH-1:0];
         w_res_hi = r_neg_r ? (~w_step[2*WIDTH-1:WIDTH] + ONE_W) : w_step[2*WIDTH-1:WIDTH];
      end else begin
         w_prod   = r_neg_q ? (~w_step + ONE_2W) : w_step;
         w_res_hi = w_prod[2*WIDTH-1:WIDTH];
         w_res_lo = w_prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_op       <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_cnt      <= '0;
         r_mag_b    <= '0;
         r_acc      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               if (start) begin
                  r_op    <= op;
                  r_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                  r_neg_r <= a_in[WIDTH-1];
                  r_mag_b <= w_mag_b;
                  r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                  r_cnt   <= '0;
                  if (op && (b_in == '0)) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign div_zero    = r_div_zero;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors, ignored start, reset abort and
// random operations checked through an expected-result queue.
module tb_mult_div_unit;

   localparam int W  = 32;
   localparam int EW = 2*W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Each entry is {div_zero, hi, lo}.
   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  m_hi = '0;
   logic [W-1:0]  m_lo = '0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .a_in       (a_in),
      .b_in       (b_in),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi         (hi),
      .lo         (lo),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result from 64-bit signed arithmetic; divide-by-zero keeps HI/LO.
   task automatic push_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit use_const, input logic [W-1:0] c_hi, input logic [W-1:0] c_lo);
      longint pa;
      longint pb;
      longint res;
      longint rem;
      logic   dz;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      dz = o && (b == '0);
      if (use_const) begin
         m_hi = c_hi;
         m_lo = c_lo;
      end else if (!dz) begin
         if (o) begin
            res  = pa / pb;
            rem  = pa % pb;
            m_lo = res[W-1:0];
            m_hi = rem[W-1:0];
         end else begin
            res  = pa * pb;
            m_lo = res[W-1:0];
            m_hi = res[2*W-1:W];
         end
      end
      exp_q.push_back({dz, m_hi, m_lo});
   endtask

   task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input int inj_k,
                         input bit use_const, input logic [W-1:0] c_hi, input logic [W-1:0] c_lo);
      int            k;
      int            busy_n;
      int            exp_lat;
      bit            got_done;
      logic [EW-1:0] e;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      push_exp(o, a, b, use_const, c_hi, c_lo);
      @(negedge clk);
      start    = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      k        = 0;
      busy_n   = 0;
      got_done = 1'b0;
      while (k <= 40 && !got_done) begin
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (busy) busy_n++;
            if (k == inj_k) begin
               start = 1'b1;
               op    = ~o;
               a_in  = 32'd9;
               b_in  = 32'd5;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            k++;
         end
      end
      start   = 1'b0;
      exp_lat = (o && b == '0) ? 0 : W;
      e       = exp_q.pop_front();
      check_eq("done_seen", 64'(got_done), 64'd1);
      check_eq("hi", 64'(hi), 64'(e[2*W-1:W]));
      check_eq("lo", 64'(lo), 64'(e[W-1:0]));
      check_eq("div_zero", 64'(div_zero), 64'(e[2*W]));
      check_eq("latency", 64'(k), 64'(exp_lat));
      check_eq("busy_cycles", 64'(busy_n), 64'(exp_lat));
      @(negedge clk);
      check_eq("done_pulse_len", 64'(done), 64'd0);
      check_eq("div_zero_pulse_len", 64'(div_zero), 64'd0);
   endtask

   initial begin
      int done_n;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_div_zero", 64'(div_zero), 64'd0);
      check_eq("rst_hi", 64'(hi), 64'd0);
      check_eq("rst_lo", 64'(lo), 64'd0);
      check_eq("rst_state", 64'(dbg_state), 64'd0);

      run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1, 1'b1, 32'h4000_0000, 32'h0000_0000);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'h0000_0000, 32'h0000_0001);
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h0000_0000, 32'h8000_0000);
      run_op(1'b1, 32'd100,       32'd7,         -1, 1'b1, 32'd2,         32'd14);
      run_op(1'b1, 32'd5,         32'd0,         -1, 1'b1, 32'd2,         32'd14);
      run_op(1'b0, 32'd3,         32'd4,         10, 1'b1, 32'd0,         32'd12);

      // Reset in the middle of a divide: no result and no done pulse.
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a_in  = 32'd100;
      b_in  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      check_eq("abort_busy", 64'(busy), 64'd0);
      check_eq("abort_hi", 64'(hi), 64'd0);
      check_eq("abort_lo", 64'(lo), 64'd0);
      check_eq("abort_state", 64'(dbg_state), 64'd0);
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) done_n++;
         @(negedge clk);
      end
      check_eq("abort_no_done", 64'(done_n), 64'd0);
      run_op(1'b0, 32'd2, 32'd3, -1, 1'b1, 32'd0, 32'd6);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 300)) - W'(150);
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 20)) - W'(10);
         if ($urandom_range(0, 7) == 0) rb = '0;
         run_op(1'($urandom_range(0, 1)), ra, rb, -1, 1'b0, '0, '0);
      end

      check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
